pattern_chain_pipe: RTL
=======================

# pattern_chain_pipe

Parametrised successor to the two-stage merged pattern netlists: a cascade of NUM_STAGES registered pattern cells on a WIDTH-bit datapath with valid/ready flow control, a per-stage function mode and an occupancy count. It sits between pattern producers and consumers, replacing fixed hand-chained pattern pairs with one configurable, backpressure-aware pipeline.

## Interface
- WIDTH, 8, datapath width in bits (≥1)
- NUM_STAGES, 3, number of pattern cells (≥1)
- OCC_W, $clog2(NUM_STAGES+1), occupancy counter width (derived, not overridden)

- blif_clk_net  input  1  single clock, all state on rising edge
- blif_reset_net  input  1  synchronous, active-high reset
- flush  input  1  synchronous: drop all in-flight beats
- mode  input  2*NUM_STAGES  stage k function = mode[2k+1:2k]
- in_valid  input  1  upstream beat present
- in_ready  output  1  pipeline accepts beat this cycle
- in_data  input  WIDTH  upstream beat
- out_valid  output  1  beat at last stage
- out_ready  input  1  downstream accepts
- out_data  output  WIDTH  last-stage register
- occ  output  OCC_W  number of valid stage registers

## Operation
- Per stage k: vld[k], dat[k], acc[k], prv[k]; all zero after reset.
- Stage k advances (loads) when upstream of it holds a beat and (!vld[k] or stage k drains this cycle); last stage drains when out_ready.
- in_ready = !vld[0] or stage 0 drains; chain is fully combinational in ready, so full throughput of 1 beat/cycle with no bubbles.
- On load with input x, dat[k] <= f(x), mode sampled in the load cycle:
  - 0 PASS: f = x
  - 1 INV: f = ~x
  - 2 XACC: f = x ^ acc[k]; acc[k] <= f
  - 3 NORP: f = ~(x | prv[k]); prv[k] <= x
- acc/prv update only on load of that stage; otherwise hold.
- out_valid = vld[NUM_STAGES-1]; out_data = dat[NUM_STAGES-1] (held stable while out_valid && !out_ready).
- occ = popcount(vld).
- flush: all vld cleared next edge, in_ready still evaluated normally but a beat offered in the flush cycle is discarded; acc/prv retained.
- blif_reset_net: vld, dat, acc, prv cleared; dominates flush and any transfer.
- Mode change with beats in flight is legal; affects only loads after the change.

## Timing
- Reset values: out_valid 0, out_data 0, occ 0, in_ready 1 (first cycle after reset released).
- Latency: beat accepted in cycle c appears as out_valid in cycle c+NUM_STAGES with empty pipeline and out_ready high.
- Full pipeline, out_ready 0: in_ready 0; when out_ready rises, in_ready rises same cycle (simultaneous drain and accept).
- Simultaneous accept and emit: occ unchanged.
- Reset asserted mid-stream: in-flight beats lost, no out_valid in the cycle after reset.
- Order preserved; no beat duplicated or dropped except by flush/reset.

## Test plan
- Reset: hold blif_reset_net 2 cycles with in_valid=1 -> out_valid=0, out_data=0x00, occ=0, in_ready=1 after release.
- WIDTH=8, NUM_STAGES=3, all PASS, out_ready=1, stream 0x01..0x05 back-to-back -> out 0x01..0x05 on consecutive cycles, first 3 cycles after first accept, occ peaks 3.
- Stage0 XACC, stages1-2 PASS, inputs 0x0F,0xF0,0xFF -> out 0x0F,0xFF,0x00; stage1 INV added -> 0xF0,0x00,0xFF.
- Stage1 NORP, others PASS, inputs 0x01,0x02 -> out 0xFE,0xFC.
- Backpressure: out_ready=0, offer 5 beats 0xA0..0xA4 -> 3 accepted, in_ready=0, occ=3; out_ready=1 -> 0xA0..0xA4 in order, no gaps once refilled.
- Flush with occ=3 -> occ=0, out_valid=0 next cycle; subsequent XACC output continues from retained acc; reset mid-stream -> acc cleared, next XACC output equals input.

Source files
------------

// File: rtl/pattern_chain_pipe.sv
// pattern_chain_pipe: cascade of NUM_STAGES registered pattern cells on a
// WIDTH-bit datapath with valid/ready flow control, a per-stage function
// mode and an occupancy count.
//
// Ports:
//   blif_clk_net    clock, all state on rising edge
//   blif_reset_net  synchronous active-high reset (clears vld/dat/acc/prv)
//   flush           drop all in-flight beats; acc/prv retained
//   mode            stage k function = mode[2k+1:2k] (PASS/INV/XACC/NORP)
//   in_valid/in_ready/in_data     upstream handshake
//   out_valid/out_ready/out_data  downstream handshake (last stage)
//   occ             number of valid stage registers
module pattern_chain_pipe #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned NUM_STAGES = 3,
    localparam int unsigned OCC_W     = $clog2(NUM_STAGES + 1)
) (
    input  logic                    blif_clk_net,
    input  logic                    blif_reset_net,
    input  logic                    flush,
    input  logic [2*NUM_STAGES-1:0] mode,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [OCC_W-1:0]        occ
);

    typedef enum logic [1:0] {
        MODE_PASS = 2'd0,
        MODE_INV  = 2'd1,
        MODE_XACC = 2'd2,
        MODE_NORP = 2'd3
    } mode_e;

    // Per-stage state
    logic [NUM_STAGES-1:0] vld;
    logic [WIDTH-1:0]      dat [NUM_STAGES];
    logic [WIDTH-1:0]      acc [NUM_STAGES];
    logic [WIDTH-1:0]      prv [NUM_STAGES];

    // Per-stage combinational control
    logic [NUM_STAGES-1:0] stage_rdy;
    logic [NUM_STAGES-1:0] drain;
    logic [NUM_STAGES-1:0] up_vld;
    logic [NUM_STAGES-1:0] load;
    logic [WIDTH-1:0]      x   [NUM_STAGES];
    logic [WIDTH-1:0]      f   [NUM_STAGES];
    mode_e                 stage_mode [NUM_STAGES];

    // Ready ripples back from the output so a full chain can drain and
    // accept in the same cycle: a stage can take a beat if it is empty or
    // everything downstream of it is moving.
    always_comb begin
        logic r;
        stage_rdy = '0;
        drain     = '0;
        r         = out_ready;
        for (int k = int'(NUM_STAGES) - 1; k >= 0; k--) begin
            drain[k]     = vld[k] & r;
            stage_rdy[k] = ~vld[k] | r;
            r            = stage_rdy[k];
        end
        in_ready = r;
    end

    // Stage inputs: stage 0 from upstream, stage k from stage k-1.
    always_comb begin
        up_vld    = '0;
        up_vld[0] = in_valid;
        for (int k = 0; k < int'(NUM_STAGES); k++) begin
            x[k] = '0;
        end
        x[0] = in_data;
        for (int k = 1; k < int'(NUM_STAGES); k++) begin
            up_vld[k] = vld[k-1];
            x[k]      = dat[k-1];
        end
    end

    // A flush cycle performs no loads, so the offered beat is discarded and
    // acc/prv are not disturbed by beats that are being dropped.
    always_comb begin
        load = '0;
        for (int k = 0; k < int'(NUM_STAGES); k++) begin
            load[k] = up_vld[k] & stage_rdy[k] & ~flush;
        end
    end

    // Stage function, using the mode present in the load cycle.
    always_comb begin
        for (int k = 0; k < int'(NUM_STAGES); k++) begin
            stage_mode[k] = mode_e'(mode[2*k +: 2]);
            f[k]          = x[k];
            case (stage_mode[k])
                MODE_PASS: f[k] = x[k];
                MODE_INV:  f[k] = ~x[k];
                MODE_XACC: f[k] = x[k] ^ acc[k];
                MODE_NORP: f[k] = ~(x[k] | prv[k]);
                default:   f[k] = x[k];
            endcase
        end
    end

    // Stage registers
    always_ff @(posedge blif_clk_net) begin
        if (blif_reset_net) begin
            vld <= '0;
            for (int k = 0; k < int'(NUM_STAGES); k++) begin
                dat[k] <= '0;
                acc[k] <= '0;
                prv[k] <= '0;
            end
        end else begin
            for (int k = 0; k < int'(NUM_STAGES); k++) begin
                if (flush) begin
                    vld[k] <= 1'b0;
                end else if (load[k]) begin
                    vld[k] <= 1'b1;
                end else if (drain[k]) begin
                    vld[k] <= 1'b0;
                end

                if (load[k]) begin
                    dat[k] <= f[k];
                    if (stage_mode[k] == MODE_XACC) begin
                        acc[k] <= f[k];
                    end
                    if (stage_mode[k] == MODE_NORP) begin
                        prv[k] <= x[k];
                    end
                end
            end
        end
    end

    // Occupancy: popcount of stage valids
    always_comb begin
        occ = '0;
        for (int k = 0; k < int'(NUM_STAGES); k++) begin
            occ = occ + OCC_W'(vld[k]);
        end
    end

    assign out_valid = vld[NUM_STAGES-1];
    assign out_data  = dat[NUM_STAGES-1];

endmodule
